change_return_dispenser: RTL and testbench

- Return-side counterpart of the vending machine's coin-input path.
- When a return is requested, it latches the customer's remaining balance and pays it back as a greedy sequence of coins, largest denomination first.
- It drives `o_return_coin` with one coin per cycle and reports the total returned and any unreturnable residue.
- It sits between the current-total logic, which supplies the balance and the trigger, and the top-level coin outputs.

---
 rtl/change_return_dispenser.sv | 136 +++++++++++++
 tb/tb_change_return_dispenser.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/change_return_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_return_dispenser
// Purpose  : Latches a customer balance on a return request and pays it back
//            as a greedy sequence of coins (largest denomination first), one
//            coin per cycle, then reports the total paid and the residue.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   i_trigger_return in   return request, sampled only while idle
//   i_balance        in   balance to return, sampled with the trigger
//   o_return_coin    out  one-hot coin dispensed this cycle (0 = none)
//   o_busy           out  high while a return session is in progress
//   o_done           out  one-cycle pulse at the end of a session
//   o_return_total   out  sum of coins returned in current/last session
//   o_residual       out  unpayable remainder, valid from o_done onward
// ============================================================================
module change_return_dispenser #(
  parameter int          kNumCoins   = 3,   // this block supports exactly 3
  parameter int          kTotalBits  = 31,
  parameter int unsigned COIN0_VALUE = 100,
  parameter int unsigned COIN1_VALUE = 500,
  parameter int unsigned COIN2_VALUE = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] i_balance,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_return_total,
  output logic [kTotalBits-1:0] o_residual
);

  localparam logic [kTotalBits-1:0] c_coin0 = kTotalBits'(COIN0_VALUE);
  localparam logic [kTotalBits-1:0] c_coin1 = kTotalBits'(COIN1_VALUE);
  localparam logic [kTotalBits-1:0] c_coin2 = kTotalBits'(COIN2_VALUE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [kTotalBits-1:0]   remaining_q, remaining_d;
  logic [kNumCoins-1:0]    coin_q, coin_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [kTotalBits-1:0]   total_q, total_d;
  logic [kTotalBits-1:0]   residual_q, residual_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      total_q     <= '0;
      residual_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      total_q     <= total_d;
      residual_q  <= residual_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = '0;         // coin is a single-cycle strobe
    busy_d      = busy_q;
    done_d      = 1'b0;       // done is a single-cycle pulse
    total_d     = total_q;
    residual_d  = residual_q;

    case (state_q)
      ST_IDLE: begin
        if (i_trigger_return) begin
          remaining_d = i_balance;
          total_d     = '0;
          residual_d  = '0;
          busy_d      = 1'b1;
          state_d     = ST_DISPENSE;
        end
      end

      ST_DISPENSE: begin
        // Each compare precedes its subtract, so remaining never wraps.
        if (remaining_q >= c_coin2) begin
          coin_d[2]   = 1'b1;
          remaining_d = remaining_q - c_coin2;
          total_d     = total_q + c_coin2;
        end else if (remaining_q >= c_coin1) begin
          coin_d[1]   = 1'b1;
          remaining_d = remaining_q - c_coin1;
          total_d     = total_q + c_coin1;
        end else if (remaining_q >= c_coin0) begin
          coin_d[0]   = 1'b1;
          remaining_d = remaining_q - c_coin0;
          total_d     = total_q + c_coin0;
        end else begin
          residual_d  = remaining_q;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_return_coin  = coin_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_return_total = total_q;
  assign o_residual     = residual_q;

endmodule
`default_nettype wire

// File: tb/tb_change_return_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_return_dispenser
// Purpose  : Self-checking bench for change_return_dispenser. Expected coin
//            sequences come from integer division of the balance by each
//            denomination, largest first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_return_dispenser;

  localparam int W = 31;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           trig = 1'b0;
  logic [W-1:0]   bal = '0;
  logic [2:0]     coin;
  logic           busy;
  logic           done;
  logic [W-1:0]   total;
  logic [W-1:0]   residual;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned coin_val [3] = '{100, 500, 1000};

  change_return_dispenser dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_trigger_return (trig),
    .i_balance        (bal),
    .o_return_coin    (coin),
    .o_busy           (busy),
    .o_done           (done),
    .o_return_total   (total),
    .o_residual       (residual)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_coin"}, 64'(coin), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Runs one session from IDLE; caller is positioned just after an edge.
  // disturb: re-pulse trigger and change balance while dispensing.
  task automatic run_session(input int unsigned b, input bit disturb);
    int unsigned rem;
    int unsigned sum;
    int          coins[$];
    logic [2:0]  exp_coin;

    rem = b;
    sum = 0;
    for (int d = 2; d >= 0; d--) begin
      for (int n = 0; n < int'(rem / coin_val[d]); n++) coins.push_back(d);
      rem = rem % coin_val[d];
    end

    trig = 1'b1;
    bal  = b[W-1:0];
    tick();  // trigger edge
    check("e0_busy",  64'(busy),     64'd1);
    check("e0_coin",  64'(coin),     64'd0);
    check("e0_done",  64'(done),     64'd0);
    check("e0_total", 64'(total),    64'd0);
    check("e0_resid", 64'(residual), 64'd0);
    trig = 1'b0;
    if (disturb) bal = 31'd300;

    foreach (coins[k]) begin
      if (disturb && k == 0) trig = 1'b1;
      tick();
      trig = 1'b0;
      sum += coin_val[coins[k]];
      exp_coin = 3'b001 << coins[k];
      check("coin",       64'(coin),  64'(exp_coin));
      check("coin_total", 64'(total), 64'(sum));
      check("coin_busy",  64'(busy),  64'd1);
      check("coin_done",  64'(done),  64'd0);
    end

    tick();  // done edge
    check("done_pulse", 64'(done),           64'd1);
    check("done_coin",  64'(coin),           64'd0);
    check("done_busy",  64'(busy),           64'd1);
    check("done_total", 64'(total),          64'(sum));
    check("done_resid", 64'(residual),       64'(rem));
    check("done_sum",   64'(total + residual), 64'(b));

    tick();  // back to idle
    check_quiet("post");
    check("post_total", 64'(total),    64'(sum));
    check("post_resid", 64'(residual), 64'(rem));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned bnd [8] = '{99, 100, 499, 500, 999, 1000, 1099, 1599};

    // Reset held with trigger asserted.
    reset_n = 1'b0;
    trig    = 1'b1;
    bal     = 31'd1700;
    repeat (3) begin
      tick();
      check_quiet("rst");
      check("rst_total", 64'(total),    64'd0);
      check("rst_resid", 64'(residual), 64'd0);
    end
    trig    = 1'b0;
    reset_n = 1'b1;
    repeat (2) begin
      tick();
      check_quiet("rel");
    end

    run_session(1700, 1'b0);
    run_session(650,  1'b0);
    run_session(50,   1'b0);
    run_session(0,    1'b0);

    // Trigger and balance changes while busy must be ignored.
    run_session(2000, 1'b1);
    repeat (2) begin
      tick();
      check_quiet("nosecond");
    end

    foreach (bnd[i]) run_session(bnd[i], 1'b0);

    // Trigger held high: re-arms at the first idle edge after DONE.
    trig = 1'b1;
    bal  = 31'd50;
    tick();
    check("hold_e0_busy", 64'(busy), 64'd1);
    tick();
    check("hold_done",    64'(done), 64'd1);
    tick();
    check("hold_idle",    64'(busy), 64'd0);
    tick();
    check("hold_restart", 64'(busy), 64'd1);
    trig = 1'b0;
    tick();
    check("hold_done2",   64'(done),     64'd1);
    check("hold_resid2",  64'(residual), 64'd50);
    tick();
    check_quiet("hold_end");

    // Reset mid-session after the second coin.
    trig = 1'b1;
    bal  = 31'd3000;
    tick();
    trig = 1'b0;
    tick();
    tick();
    check("mid_coin2",  64'(coin),  64'd4);
    check("mid_total2", 64'(total), 64'd2000);
    #1 reset_n = 1'b0;
    #1;
    check_quiet("mid_rst");
    check("mid_total", 64'(total), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      tick();
      check_quiet("mid_after");
      check("mid_after_total", 64'(total), 64'd0);
    end

    // Random balances.
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) run_session($urandom_range(0, 150), 1'b0);
      else                           run_session($urandom_range(0, 12000), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_quiet("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
